// File: rtl/systolic_sequencer.sv
// Job sequencer for an ARRAY_N x ARRAY_N weight-stationary MAC array: weight load, skewed activation stream, drain.
// Latency: first weight read the cycle after start; done pulses 2*ARRAY_N+K (+ARRAY_N if loading) cycles after start.
// Backpressure: none by default; with SEQ_STALL_EN the stall input freezes the sequence and masks all strobes.
module systolic_sequencer #(
   parameter int ARRAY_N  = 4,
   parameter int CNT_W    = 16,
   parameter int W_ADDR_W = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                reuse_w,
   input  logic [W_ADDR_W-1:0] w_base,
   input  logic [CNT_W-1:0]    num_rows,
`ifdef SEQ_STALL_EN
   input  logic                stall,
`endif
   output logic                busy,
   output logic                done,
   output logic                instr,
   output logic [31:0]         mac_matrix_counter,
   output logic                w_rd_en,
   output logic [W_ADDR_W-1:0] w_rd_addr,
   output logic                act_rd_en,
   output logic [CNT_W-1:0]    act_rd_addr,
   output logic [ARRAY_N-1:0]  row_en,
   output logic [ARRAY_N-1:0]  col_valid,
   output logic [CNT_W-1:0]    res_wr_addr
);

   localparam int S_W = CNT_W + 2;
   localparam int I_W = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD_W = 3'd1;
   localparam logic [2:0] STREAM = 3'd2;
   localparam logic [2:0] DRAIN  = 3'd3;
   localparam logic [2:0] FINISH = 3'd4;

   logic [2:0]           r_state;
   logic [W_ADDR_W-1:0]  r_w_base;
   logic [CNT_W-1:0]     r_k;
   logic                 r_wvalid;
   logic [I_W-1:0]       r_i;
   logic [S_W-1:0]       r_s;
   logic [2*ARRAY_N-2:0] r_skew;

   logic                 w_stall;
   logic                 w_act_live;
   logic [2*ARRAY_N-1:0] w_taps;
   logic [S_W-1:0]       w_last_s;
   logic [S_W-1:0]       w_drain_end;
   logic                 w_any_col;

`ifdef SEQ_STALL_EN
   assign w_stall = stall & ((r_state == LOAD_W) | (r_state == STREAM) | (r_state == DRAIN));
`else
   assign w_stall = 1'b0;
`endif

   assign w_last_s    = {2'b00, r_k} - S_W'(1);
   assign w_drain_end = {2'b00, r_k} + S_W'(2*ARRAY_N - 2);

   // Tap 0 is the live activation strobe; the registered taps delay it by 1..2N-1 cycles.
   assign w_act_live = (r_state == STREAM);
   assign w_taps     = {r_skew, w_act_live};
   assign w_any_col  = |w_taps[2*ARRAY_N-1:ARRAY_N];

   assign busy               = (r_state != IDLE);
   assign done               = (r_state == FINISH);
   assign instr              = (r_state == LOAD_W);
   assign mac_matrix_counter = 32'(r_s);
   assign w_rd_en            = (r_state == LOAD_W) & ~w_stall;
   assign w_rd_addr          = (r_state == LOAD_W) ?
                               (r_w_base + W_ADDR_W'(ARRAY_N - 1) - W_ADDR_W'(r_i)) : '0;
   assign act_rd_en          = w_act_live & ~w_stall;
   assign act_rd_addr        = w_act_live ? r_s[CNT_W-1:0] : '0;
   assign row_en             = w_taps[ARRAY_N-1:0] & {ARRAY_N{~w_stall}};
   assign col_valid          = w_taps[2*ARRAY_N-1:ARRAY_N] & {ARRAY_N{~w_stall}};
   // Address selection ignores the stall mask so the address holds across a stall.
   assign res_wr_addr        = w_any_col ? (r_s[CNT_W-1:0] - CNT_W'(ARRAY_N)) : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_skew <= '0;
      end else if (!w_stall) begin
         r_skew <= w_taps[2*ARRAY_N-2:0];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_w_base <= '0;
         r_k      <= '0;
         r_wvalid <= 1'b0;
         r_i      <= '0;
         r_s      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_w_base <= w_base;
                  r_k      <= num_rows;
                  r_i      <= '0;
                  r_s      <= '0;
                  if (num_rows == '0)
                     r_state <= FINISH;
                  else if (reuse_w && r_wvalid)
                     r_state <= STREAM;
                  else
                     r_state <= LOAD_W;
               end
            end
            LOAD_W: begin
               if (!w_stall) begin
                  if (r_i == I_W'(ARRAY_N - 1)) begin
                     r_i      <= '0;
                     r_wvalid <= 1'b1;
                     r_state  <= STREAM;
                  end else begin
                     r_i <= r_i + I_W'(1);
                  end
               end
            end
            STREAM: begin
               if (!w_stall) begin
                  r_s <= r_s + S_W'(1);
                  if (r_s == w_last_s)
                     r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!w_stall) begin
                  if (r_s == w_drain_end) begin
                     r_s     <= '0;
                     r_state <= FINISH;
                  end else begin
                     r_s <= r_s + S_W'(1);
                  end
               end
            end
            FINISH: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer (ARRAY_N=4): per-cycle output table plus reset and stall sequences.
module tb_systolic_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        reuse_w;
   logic [7:0]  w_base;
   logic [15:0] num_rows;
`ifdef SEQ_STALL_EN
   logic        stall;
`endif
   logic        busy, done, instr, w_rd_en, act_rd_en;
   logic [31:0] mac_matrix_counter;
   logic [7:0]  w_rd_addr;
   logic [15:0] act_rd_addr, res_wr_addr;
   logic [3:0]  row_en, col_valid;

   systolic_sequencer #(.ARRAY_N(4), .CNT_W(16), .W_ADDR_W(8)) dut (
      .clock(clock), .reset(reset), .start(start), .reuse_w(reuse_w),
      .w_base(w_base), .num_rows(num_rows),
`ifdef SEQ_STALL_EN
      .stall(stall),
`endif
      .busy(busy), .done(done), .instr(instr), .mac_matrix_counter(mac_matrix_counter),
      .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
      .row_en(row_en), .col_valid(col_valid), .res_wr_addr(res_wr_addr)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        busy, done, instr;
      logic [31:0] mcc;
      logic        w_en;
      logic [7:0]  w_addr;
      logic        a_en;
      logic [15:0] a_addr;
      logic [3:0]  row, col;
      logic [15:0] res;
   } out_t;

   typedef struct {
      logic        st, ru;
      logic [7:0]  wb;
      logic [15:0] k;
      out_t        e;
   } vec_t;

   out_t obs;
   assign obs = {busy, done, instr, mac_matrix_counter, w_rd_en, w_rd_addr,
                 act_rd_en, act_rd_addr, row_en, col_valid, res_wr_addr};

   vec_t vecs[$];
   int   pass_cnt = 0;
   int   total    = 0;

   function automatic out_t ld(logic [7:0] a);
      return {1'b1, 1'b0, 1'b1, 32'd0, 1'b1, a, 1'b0, 16'd0, 4'd0, 4'd0, 16'd0};
   endfunction
   function automatic out_t sm(logic [31:0] s, logic [3:0] re);
      return {1'b1, 1'b0, 1'b0, s, 1'b0, 8'd0, 1'b1, s[15:0], re, 4'd0, 16'd0};
   endfunction
   function automatic out_t dr(logic [31:0] s, logic [3:0] re, logic [3:0] cv, logic [15:0] rs);
      return {1'b1, 1'b0, 1'b0, s, 1'b0, 8'd0, 1'b0, 16'd0, re, cv, rs};
   endfunction
   function automatic out_t fin();
      return {1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 16'd0, 4'd0, 4'd0, 16'd0};
   endfunction

   function automatic void add(logic st, logic ru, logic [7:0] wb, logic [15:0] k, out_t e);
      vec_t v;
      v.st = st; v.ru = ru; v.wb = wb; v.k = k; v.e = e;
      vecs.push_back(v);
   endfunction
   function automatic void add_o(out_t e);
      add(1'b0, 1'b0, 8'd0, 16'd0, e);
   endfunction

   task automatic check_o(string name, out_t act, out_t exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask
   task automatic check_v(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   initial begin
      int done_seen;
      int found;
      reset = 1'b0; start = 1'b0; reuse_w = 1'b0; w_base = '0; num_rows = '0;
`ifdef SEQ_STALL_EN
      stall = 1'b0;
`endif
      // Job 1: load weights from base 8, K=3; a stray start mid-job must be ignored.
      add(1, 0, 8'd8, 16'd3, '0);
      add_o(ld(8'd11)); add_o(ld(8'd10)); add_o(ld(8'd9)); add_o(ld(8'd8));
      add_o(sm(0, 4'b0001));
      add(1, 0, 8'd50, 16'd5, sm(1, 4'b0011));
      add_o(sm(2, 4'b0111));
      add_o(dr(3, 4'b1110, 4'b0000, 0)); add_o(dr(4, 4'b1100, 4'b0001, 0));
      add_o(dr(5, 4'b1000, 4'b0011, 1)); add_o(dr(6, 4'b0000, 4'b0111, 2));
      add_o(dr(7, 4'b0000, 4'b1110, 3)); add_o(dr(8, 4'b0000, 4'b1100, 4));
      add_o(dr(9, 4'b0000, 4'b1000, 5));
      add_o(fin()); add_o('0);
      // Job 2: reuse weights, K=2.
      add(1, 1, 8'd8, 16'd2, '0);
      add_o(sm(0, 4'b0001)); add_o(sm(1, 4'b0011));
      add_o(dr(2, 4'b0110, 4'b0000, 0)); add_o(dr(3, 4'b1100, 4'b0000, 0));
      add_o(dr(4, 4'b1000, 4'b0001, 0)); add_o(dr(5, 4'b0000, 4'b0011, 1));
      add_o(dr(6, 4'b0000, 4'b0110, 2)); add_o(dr(7, 4'b0000, 4'b1100, 3));
      add_o(dr(8, 4'b0000, 4'b1000, 4));
      add_o(fin()); add_o('0);
      // Job 3: K=0 finishes immediately and leaves the weights resident.
      add(1, 0, 8'd8, 16'd0, '0);
      add_o(fin()); add_o('0);
      // Job 4: reuse, K=1 goes straight to STREAM.
      add(1, 1, 8'd3, 16'd1, '0);
      add_o(sm(0, 4'b0001));
      add_o(dr(1, 4'b0010, 4'b0000, 0)); add_o(dr(2, 4'b0100, 4'b0000, 0));
      add_o(dr(3, 4'b1000, 4'b0000, 0)); add_o(dr(4, 4'b0000, 4'b0001, 0));
      add_o(dr(5, 4'b0000, 4'b0010, 1)); add_o(dr(6, 4'b0000, 4'b0100, 2));
      add_o(dr(7, 4'b0000, 4'b1000, 3));
      add_o(fin()); add_o('0);

      repeat (2) @(negedge clock);
      #1 check_o("reset_state", obs, '0);
      @(negedge clock) reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clock);
         start = vecs[i].st; reuse_w = vecs[i].ru; w_base = vecs[i].wb; num_rows = vecs[i].k;
         #1 check_o($sformatf("vec%0d", i), obs, vecs[i].e);
      end

      // Reset during STREAM at s=1 aborts the job and clears the resident-weight flag.
      @(negedge clock);
      start = 1'b1; reuse_w = 1'b1; w_base = 8'd8; num_rows = 16'd3;
      @(negedge clock) start = 1'b0;
      @(negedge clock);
      #1 check_o("stream_s1", obs, sm(1, 4'b0011));
      reset = 1'b0;
      #1 check_o("reset_mid", obs, '0);
      done_seen = 0;
      repeat (3) begin
         @(negedge clock);
         if (done) done_seen++;
      end
      reset = 1'b1;
      repeat (12) begin
         @(negedge clock);
         if (done) done_seen++;
      end
      check_v("no_done_after_abort", done_seen, 0);
      start = 1'b1; reuse_w = 1'b1; w_base = 8'd4; num_rows = 16'd1;
      @(negedge clock) start = 1'b0;
      #1 check_o("reload_after_reset", obs, ld(8'd7));
      found = 0;
      for (int c = 0; c < 40 && found == 0; c++) begin
         @(negedge clock);
         #1 if (done) found = 1;
      end
      check_v("done_after_reload", found, 1);
      @(negedge clock);

`ifdef SEQ_STALL_EN
      begin
         logic [16:0] exp_act [5:9];
         int done_row;
         exp_act[5] = {1'b1, 16'd0}; exp_act[6] = {1'b0, 16'd1}; exp_act[7] = {1'b0, 16'd1};
         exp_act[8] = {1'b1, 16'd1}; exp_act[9] = {1'b1, 16'd2};
         done_row = 0;
         @(negedge clock);
         start = 1'b1; reuse_w = 1'b0; w_base = 8'd8; num_rows = 16'd3;
         for (int r = 1; r <= 20; r++) begin
            @(negedge clock);
            start = 1'b0;
            stall = (r == 6 || r == 7);
            #1;
            if (r >= 5 && r <= 9)
               check_v($sformatf("stall_act_r%0d", r), {15'd0, act_rd_en, act_rd_addr}, {15'd0, exp_act[r]});
            if (done && done_row == 0) done_row = r;
         end
         stall = 1'b0;
         check_v("stall_done_row", done_row, 17);
      end
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
